shift_ll_seq: RTL

- Multi-cycle logical left shifter (RV32 SLL/SLLI) for the execute stage; the left-shift counterpart of the combinational arithmetic-right shifter.
- Trades area for latency: one log-shifter stage (16/8/4/2/1) is evaluated per clock.
- Valid/ready handshake on both sides, so it can sit behind a stall-capable issue slot.
- Optional early termination skips trailing zero amount bits.

---
 rtl/shift_ll_seq_if.sv | 27 ++
 rtl/shift_ll_seq.sv | 99 +++++++++
 2 files changed

// File: rtl/shift_ll_seq_if.sv
// Request/response bundle for the multi-cycle logical left shifter.
// master = requester/consumer side, slave = shifter side.
interface shift_ll_seq_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned AMT_W = 5;

    logic             i_valid;
    logic             o_ready;
    logic [XLEN-1:0]  i_rs;
    logic [AMT_W-1:0] i_amount;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_result;
    logic             o_busy;

    modport master (
        output i_valid, i_rs, i_amount, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_busy
    );

    modport slave (
        input  i_valid, i_rs, i_amount, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_busy
    );
endinterface

// File: rtl/shift_ll_seq.sv
// Multi-cycle RV32 SLL/SLLI: one log-shifter stage (16/8/4/2/1) per clock.
// Define SHIFT_LL_EARLY_EXIT_EN to finish once the remaining amount bits are zero.
module shift_ll_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    shift_ll_seq_if.slave bus
);
    localparam int unsigned AMT_W = 5;
    localparam int unsigned STG_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  data_q,  data_d;
    logic [AMT_W-1:0] amt_q,   amt_d;
    logic [STG_W-1:0] stage_q, stage_d;

    logic             ready_c;
    logic             accept_c;
    logic             last_stage_c;
    logic [AMT_W-1:0] step_c;

    // A result in DONE can be handed off and replaced on the same edge.
    assign ready_c  = (state_q == IDLE) || ((state_q == DONE) && bus.i_ready);
    assign accept_c = bus.i_valid && ready_c;
    assign step_c   = AMT_W'(1) << stage_q;

`ifdef SHIFT_LL_EARLY_EXIT_EN
    logic [AMT_W-1:0] low_mask_c;

    // Stop as soon as no lower amount bit remains to be applied.
    assign low_mask_c   = step_c - AMT_W'(1);
    assign last_stage_c = (stage_q == '0) || ((amt_q & low_mask_c) == '0);
`else
    assign last_stage_c = (stage_q == '0);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            stage_q <= stage_d;
        end
    end

    // Flush outranks everything, including a same-edge accept.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        amt_d   = amt_q;
        stage_d = stage_q;

        if (bus.i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_c) begin
                        data_d  = bus.i_rs;
                        amt_d   = bus.i_amount;
                        stage_d = STG_W'(4);
                        state_d = SHIFT;
                    end else if ((state_q == DONE) && bus.i_ready) begin
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    if (amt_q[stage_q]) begin
                        data_d = data_q << step_c;
                    end
                    if (last_stage_c) begin
                        stage_d = '0;
                        state_d = DONE;
                    end else begin
                        stage_d = stage_q - STG_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.o_ready  = ready_c;
    assign bus.o_valid  = (state_q == DONE);
    assign bus.o_busy   = (state_q == SHIFT);
    assign bus.o_result = data_q;
endmodule
